// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice per cycle, LSB first, with a FIXUP step for SLT.
// Result flags are registered at DONE entry and held until the next DONE entry.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_set;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sh;

  logic               w_last;
  logic               w_ai;
  logic               w_bi;
  logic               w_g;
  logic               w_p;
  logic               w_x;
  logic               w_s;
  logic               w_cout;
  logic               w_ov;
  logic               w_bit;
  logic [WIDTH-1:0]   w_res;

  function automatic logic f_legal(input logic [2:0] o);
    return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) ||
           (o == OP_SUB) || (o == OP_SLT);
  endfunction

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = (r_op == OP_SLT) ? S_FIXUP : S_DONE;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Operands shift right each RUN cycle, so bit i always sits at position 0 in cycle i.
  always_comb begin
    w_ai   = r_a[0];
    w_bi   = r_b[0] ^ r_op[2];
    w_g    = w_ai & w_bi;
    w_p    = w_ai | w_bi;
    w_x    = w_ai ^ w_bi;
    w_s    = w_x ^ r_carry;
    w_cout = w_g | (w_x & r_carry);
    w_ov   = r_carry ^ w_cout;
    case (r_op)
      OP_AND:         w_bit = w_g;
      OP_OR:          w_bit = w_p;
      OP_ADD, OP_SUB: w_bit = w_s;
      default:        w_bit = 1'b0;
    endcase
    w_res = {w_bit, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_a  <= a;
          r_b  <= b;
          r_op <= op;
          r_sh <= '0;
        end
      end
      S_RUN: begin
        r_a  <= r_a >> 1;
        r_b  <= r_b >> 1;
        r_sh <= w_res;
        if (w_last) r_set <= w_s ^ w_ov;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_carry <= (op == OP_SUB) || (op == OP_SLT);
          end
        end
        S_RUN: begin
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt <= '0;
            if (r_op != OP_SLT) begin
              result     <= w_res;
              zero       <= (w_res == '0);
              overflow   <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_ov : 1'b0;
              illegal_op <= !f_legal(r_op);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // SLT: sign of A-B corrected by its overflow gives the signed less-than bit
        S_FIXUP: begin
          result     <= {{(WIDTH-1){1'b0}}, r_set};
          zero       <= !r_set;
          overflow   <= 1'b0;
          illegal_op <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
